box_mean: RTL and testbench

Downstream stage of the three-line column adder. It consumes the 10-bit vertical 3-row sum stream, one sample per enabled cycle, and forms a horizontal 3-tap window of those column sums. Each window total is divided by 9, so the block emits the 8-bit 3×3 box-filter mean for the centre pixel. It also restarts the window at every line boundary so no window spans two lines.

---
 rtl/box_pkg.sv | 19 +
 rtl/div9_recip.sv | 45 ++++
 rtl/box_mean.sv | 114 +++++++++++
 tb/tb_box_mean.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared constants for the 3x3 box-filter chain: stream widths, the reciprocal
// used for the divide-by-9 and the default line length. The column adder and
// later filter stages use the same values, so they are kept in one place.
package box_pkg;

   // Data widths along the filter chain
   localparam int SUM_W        = 10;   // vertical 3-row sum, 0..765
   localparam int ACC_W        = 12;   // 3x3 window total, 0..2295
   localparam int MEAN_W       = 8;    // filtered pixel
   localparam int COL_W        = 12;   // column index, covers LINE_LEN up to 4095

   // floor(x/9) == (x * 7282) >> 16 for every x <= 2303
   localparam int RECIP9       = 7282;
   localparam int RECIP_SHIFT  = 16;
   localparam int PROD_W       = 25;   // 2295 * 7282 fits in 24 bits

   localparam int LINE_LEN_DEF = 640;

endpackage : box_pkg

// File: rtl/div9_recip.sv
// Registered divide-by-9 for window totals up to 2303, done as a multiply by
// the fixed-point reciprocal 7282/65536. The quotient register holds its value
// while no valid total arrives.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   acc        - window total to divide (ACC_W bits)
//   acc_valid  - acc is valid this cycle
//   quot       - registered floor(acc/9) (MEAN_W bits)
//   quot_valid - registered copy of acc_valid
module div9_recip
   import box_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ACC_W-1:0]  acc,
   input  logic              acc_valid,
   output logic [MEAN_W-1:0] quot,
   output logic              quot_valid
);

   logic [PROD_W-1:0] prod_s;

   // Reciprocal product; only bits [23:16] carry the quotient
   always_comb begin
      prod_s = PROD_W'(acc) * PROD_W'(RECIP9);
   end

   // Quotient and valid registers; quotient updates only on valid totals
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quot       <= {MEAN_W{1'b0}};
         quot_valid <= 1'b0;
      end else begin
         quot_valid <= acc_valid;
         if (acc_valid) begin
            quot <= prod_s[RECIP_SHIFT+MEAN_W-1:RECIP_SHIFT];
         end else begin
            quot <= quot;
         end
      end
   end

endmodule : div9_recip

// File: rtl/box_mean.sv
// Horizontal stage of the 3x3 box filter. Takes the stream of vertical 3-row
// column sums, forms a 3-tap horizontal window, adds it and divides by 9 to
// produce the box mean of the centre pixel. The window restarts at every line
// boundary: the first two samples of a line only prime it, so no output ever
// mixes two lines. Fixed latency of 3 cycles, one result per clock maximum.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - sum carries a valid column sample
//   sum        - vertical 3-row sum, 0..765
//   mean       - floor(window total / 9), held between results
//   mean_valid - one-cycle pulse per result
//   mean_last  - marks the last result of a line
module box_mean
   import box_pkg::*;
#(
   parameter int LINE_LEN = LINE_LEN_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [SUM_W-1:0]  sum,
   output logic [MEAN_W-1:0] mean,
   output logic              mean_valid,
   output logic              mean_last
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

   logic [COL_W-1:0]  col_r;
   logic [SUM_W-1:0]  w0_r, w1_r, w2_r;
   logic              v1_r, last1_r;
   logic [ACC_W-1:0]  acc_r;
   logic              v2_r, last2_r;
   logic              mean_last_r;

   // Column counter: advances on accepted samples, wraps at end of line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r <= {COL_W{1'b0}};
      end else if (in_valid) begin
         if (col_r == COL_LAST) begin
            col_r <= {COL_W{1'b0}};
         end else begin
            col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
         end
      end else begin
         col_r <= col_r;
      end
   end

   // Window shift register and stage-1 flags. Old-line data left in the
   // window is harmless: columns 0 and 1 never raise v1, and by column 2 it
   // has been shifted out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w0_r    <= {SUM_W{1'b0}};
         w1_r    <= {SUM_W{1'b0}};
         w2_r    <= {SUM_W{1'b0}};
         v1_r    <= 1'b0;
         last1_r <= 1'b0;
      end else begin
         v1_r    <= in_valid & (col_r >= 12'd2);
         last1_r <= in_valid & (col_r == COL_LAST);
         if (in_valid) begin
            w2_r <= w1_r;
            w1_r <= w0_r;
            w0_r <= sum;
         end else begin
            w2_r <= w2_r;
            w1_r <= w1_r;
            w0_r <= w0_r;
         end
      end
   end

   // Stage 2: window total; valids advance every cycle so results drain
   // through input gaps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= {ACC_W{1'b0}};
         v2_r    <= 1'b0;
         last2_r <= 1'b0;
      end else begin
         acc_r   <= {2'b00, w0_r} + {2'b00, w1_r} + {2'b00, w2_r};
         v2_r    <= v1_r;
         last2_r <= v1_r & last1_r;
      end
   end

   // Stage 3: divide by 9
   div9_recip u_div9 (
      .clk        (clk),
      .rst        (rst),
      .acc        (acc_r),
      .acc_valid  (v2_r),
      .quot       (mean),
      .quot_valid (mean_valid)
   );

   // End-of-line flag registered alongside the stage-3 divider
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mean_last_r <= 1'b0;
      end else begin
         mean_last_r <= last2_r;
      end
   end

   assign mean_last = mean_last_r;

endmodule : box_mean

// File: tb/tb_box_mean.sv
// Directed bench for box_mean with LINE_LEN=8. Each driven sample carries its
// hand-computed expected result; a 3-deep delay line lines that expectation up
// with the DUT output three cycles later. While no result is expected, mean
// must hold the previous result.
module tb_box_mean;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [9:0] sum;
   logic [7:0] mean;
   logic       mean_valid;
   logic       mean_last;

   int checks = 0;
   int errors = 0;

   // expectation delay line, index 2 is the oldest
   logic       q_v [0:2];
   logic [7:0] q_m [0:2];
   logic       q_l [0:2];
   logic [7:0] held;

   logic [7:0] ramp_m [0:7];

   box_mean #(.LINE_LEN(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .sum        (sum),
      .mean       (mean),
      .mean_valid (mean_valid),
      .mean_last  (mean_last)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      for (int i = 0; i < 3; i++) begin
         q_v[i] = 1'b0;
         q_m[i] = 8'd0;
         q_l[i] = 1'b0;
      end
   endtask

   // One clock: check outputs due now, then drive the next sample and queue
   // the result that sample should produce.
   task automatic cyc(input logic v, input logic [9:0] s,
                      input logic ev, input logic [7:0] em, input logic el);
      logic [7:0] exp_mean;
      @(negedge clk);
      exp_mean = q_v[2] ? q_m[2] : held;
      check_bit("mean_valid", mean_valid, q_v[2]);
      check_byte("mean", mean, exp_mean);
      check_bit("mean_last", mean_last, q_l[2]);
      held = exp_mean;
      for (int i = 2; i > 0; i--) begin
         q_v[i] = q_v[i-1];
         q_m[i] = q_m[i-1];
         q_l[i] = q_l[i-1];
      end
      q_v[0] = ev;
      q_m[0] = em;
      q_l[0] = el;
      in_valid = v;
      sum = s;
   endtask

   task automatic line_const(input logic [9:0] s, input logic [7:0] m);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, s, (i >= 2), m, (i == 7));
      end
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
      end
   endtask

   initial begin
      ramp_m = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
      clear_q();
      held     = 8'd0;
      rst      = 1'b1;
      in_valid = 1'b0;
      sum      = 10'd0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_byte("reset mean", mean, 8'd0);
      check_bit("reset mean_valid", mean_valid, 1'b0);
      check_bit("reset mean_last", mean_last, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // constant line: 90*3/9 = 30
      line_const(10'd90, 8'd30);
      // saturation: 765*3 = 2295 -> 255
      line_const(10'd765, 8'd255);

      // ramp 0..7: windows 3,6,9,12,15,18
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 10'(i), (i >= 2), ramp_m[i], (i == 7));
      end

      // exact division boundaries: 8->0, 9->1, 10->1, 9->1, 7->0, 6->0
      cyc(1'b1, 10'd1, 1'b0, 8'd0, 1'b0);
      cyc(1'b1, 10'd2, 1'b0, 8'd0, 1'b0);
      cyc(1'b1, 10'd5, 1'b1, 8'd0, 1'b0);
      cyc(1'b1, 10'd2, 1'b1, 8'd1, 1'b0);
      cyc(1'b1, 10'd3, 1'b1, 8'd1, 1'b0);
      cyc(1'b1, 10'd4, 1'b1, 8'd1, 1'b0);
      cyc(1'b1, 10'd0, 1'b1, 8'd0, 1'b0);
      cyc(1'b1, 10'd2, 1'b1, 8'd0, 1'b1);

      // gapped ramp: same means, each 3 cycles after its completing sample
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 10'(i), (i >= 2), ramp_m[i], (i == 7));
         cyc(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
      end

      // line wrap: all-zero line then all-90 line back to back
      line_const(10'd0, 8'd0);
      line_const(10'd90, 8'd30);
      flush(4);

      // reset mid-line with results in flight
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 10'd90, (i >= 2), 8'd30, 1'b0);
      end
      @(posedge clk);
      #1;
      check_bit("inflight mean_valid", mean_valid, 1'b1);
      check_byte("inflight mean", mean, 8'd30);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check_byte("async rst mean", mean, 8'd0);
      check_bit("async rst mean_valid", mean_valid, 1'b0);
      check_bit("async rst mean_last", mean_last, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_bit("held rst mean_valid", mean_valid, 1'b0);
      clear_q();
      held = 8'd0;
      @(negedge clk);
      rst = 1'b0;

      // fresh line after reset: 60*3/9 = 20, first result after 3rd sample
      line_const(10'd60, 8'd20);
      flush(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_box_mean
